prince_affine_inv_2sh_serial: RTL and testbench



---
 rtl/prince_mask_pkg.sv | 75 +++++++
 rtl/prince_affine_inv_2sh_serial_affine_inv_2sh.sv | 32 +++
 rtl/prince_affine_inv_2sh_serial.sv | 214 +++++++++++++++++++++
 tb/tb_prince_affine_inv_2sh_serial.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prince_mask_pkg.sv
// ============================================================================
//  Module      : prince_mask_pkg
//  Description : Shared types and lookup tables for the two-share PRINCE
//                affine layer. The forward share functions are:
//                  A1(x) = L(x) ^ AFFINE_C   (share 1, carries the constant)
//                  A2(x) = L(x)              (share 2, linear only)
//                with L the 4-bit linear map
//                  y0 = x0^x1, y1 = x1^x2, y2 = x2^x3, y3 = x3.
//                The inverse tables are built by scattering the forward
//                functions, so they cannot drift from them. LUTS_OK confirms
//                that each table really undoes its forward function.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package prince_mask_pkg;

  typedef logic [3:0]       nibble_t;
  typedef logic [63:0]      state_t;
  typedef logic [15:0][3:0] lut_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fsm_t;

  localparam nibble_t AFFINE_C = 4'h5;

  function automatic nibble_t lin_fwd(input nibble_t x);
    return {x[3], x[2] ^ x[3], x[1] ^ x[2], x[0] ^ x[1]};
  endfunction

  function automatic nibble_t a1_fwd(input nibble_t x);
    return lin_fwd(x) ^ AFFINE_C;
  endfunction

  function automatic nibble_t a2_fwd(input nibble_t x);
    return lin_fwd(x);
  endfunction

  // Inverse table: entry fwd(x) holds x.
  function automatic lut_t invert_lut(input logic share1);
    lut_t    lut;
    nibble_t x;
    nibble_t y;
    lut = '0;
    for (int i = 0; i < 16; i++) begin
      x      = nibble_t'(i);
      y      = share1 ? a1_fwd(x) : a2_fwd(x);
      lut[y] = x;
    end
    return lut;
  endfunction

  // A non-bijective forward map would leave holes that fail this round trip.
  function automatic logic luts_ok(input lut_t inv1, input lut_t inv2);
    logic    ok;
    nibble_t x;
    ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      x = nibble_t'(i);
      if (inv1[a1_fwd(x)] != x) ok = 1'b0;
      if (inv2[a2_fwd(x)] != x) ok = 1'b0;
    end
    return ok;
  endfunction

  localparam lut_t AINV1_LUT = invert_lut(1'b1);
  localparam lut_t AINV2_LUT = invert_lut(1'b0);
  localparam logic LUTS_OK   = luts_ok(AINV1_LUT, AINV2_LUT);

endpackage

`default_nettype wire

// File: rtl/prince_affine_inv_2sh_serial_affine_inv_2sh.sv
// ============================================================================
//  Module      : affine_inv_2sh
//  Description : Combinational inverse affine map for one nibble of one share.
//                SHARE = 1 selects AINV1 (undoes the constant as well),
//                SHARE = 2 selects AINV2 (linear only). Each share gets its own
//                instance so the two shares never meet in the same cell.
//  Ports       : i_nib  in  4  input nibble of the selected share
//                o_nib  out 4  inverse-affine nibble of the same share
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module affine_inv_2sh
  import prince_mask_pkg::*;
#(
  parameter int SHARE = 1
) (
  input  nibble_t i_nib,
  output nibble_t o_nib
);

  generate
    if (SHARE == 1) begin : g_share1
      assign o_nib = AINV1_LUT[i_nib];
    end else begin : g_share2
      assign o_nib = AINV2_LUT[i_nib];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/prince_affine_inv_2sh_serial.sv
// ============================================================================
//  Module      : prince_affine_inv_2sh_serial
//  Description : Serial two-share inverse of the PRINCE S-box affine layer.
//                A 64-bit shared state is accepted, LANES nibbles of each
//                share are transformed per cycle while the share registers
//                rotate right, and the shared result is offered on a
//                valid/ready port. Shares are kept in separate registers and
//                separate per-lane instances and are never combined.
//  Ports       : clk        in  1   clock, rising edge
//                rst_n      in  1   asynchronous active-low reset
//                in_valid   in  1   input state available
//                in_ready   out 1   block can accept a state (IDLE)
//                in_sh1     in  64  input share 1, nibble i = [4i+3:4i]
//                in_sh2     in  64  input share 2
//                in_rnd     in  64  refresh mask (PRINCE_AFFINE_INV_REFRESH_EN)
//                out_valid  out 1   result available (DONE)
//                out_ready  in  1   consumer accepts result
//                out_sh1    out 64  result share 1
//                out_sh2    out 64  result share 2
//  Options     : PRINCE_AFFINE_INV_REFRESH_EN - both shares are XORed with
//                in_rnd at the accept edge (unmasked value unchanged).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prince_affine_inv_2sh_serial
  import prince_mask_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int NIBBLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_sh1,
  input  logic [63:0] in_sh2,
`ifdef PRINCE_AFFINE_INV_REFRESH_EN
  input  logic [63:0] in_rnd,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_sh1,
  output logic [63:0] out_sh2
);

  localparam int STEPS  = NIBBLES / LANES;
  localparam int LANE_W = 4 * LANES;
  localparam int CNT_W  = $clog2(NIBBLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16))
    begin : g_bad_lanes
      $error("prince_affine_inv_2sh_serial: LANES must be 1, 2, 4, 8 or 16");
    end
    if (NIBBLES != 16) begin : g_bad_nibbles
      $error("prince_affine_inv_2sh_serial: NIBBLES is fixed at 16");
    end
    if (!LUTS_OK) begin : g_bad_luts
      $error("prince_affine_inv_2sh_serial: inverse tables do not undo forward maps");
    end
  endgenerate

  fsm_t             state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_t           sh1_q, sh1_d;
  state_t           sh2_q, sh2_d;

  logic             w_load;
  logic             w_step;

  logic [LANE_W-1:0] w_inv1;
  logic [LANE_W-1:0] w_inv2;
  state_t            w_rot1;
  state_t            w_rot2;
  state_t            w_load1;
  state_t            w_load2;

  // --------------------------------------------------------------------------
  // Load values: optional refresh XORs the same mask into both shares, which
  // leaves share1 ^ share2 untouched.
  // --------------------------------------------------------------------------
`ifdef PRINCE_AFFINE_INV_REFRESH_EN
  assign w_load1 = in_sh1 ^ in_rnd;
  assign w_load2 = in_sh2 ^ in_rnd;
`else
  assign w_load1 = in_sh1;
  assign w_load2 = in_sh2;
`endif

  // --------------------------------------------------------------------------
  // Per-lane inverse affine, one instance per share per lane.
  // --------------------------------------------------------------------------
  generate
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      affine_inv_2sh #(.SHARE(1)) u_sh1 (
        .i_nib (sh1_q[4*l +: 4]),
        .o_nib (w_inv1[4*l +: 4])
      );
      affine_inv_2sh #(.SHARE(2)) u_sh2 (
        .i_nib (sh2_q[4*l +: 4]),
        .o_nib (w_inv2[4*l +: 4])
      );
    end
  endgenerate

  // Rotate right by one lane group: transformed nibbles re-enter at the top,
  // so after STEPS cycles every nibble is back in its original position.
  generate
    if (LANES == NIBBLES) begin : g_rot_full
      assign w_rot1 = w_inv1;
      assign w_rot2 = w_inv2;
    end else begin : g_rot_part
      assign w_rot1 = {w_inv1, sh1_q[63:LANE_W]};
      assign w_rot2 = {w_inv2, sh2_q[63:LANE_W]};
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    w_load  = 1'b0;
    w_step  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = BUSY;
          cnt_d   = '0;
          w_load  = 1'b1;
        end
      end
      BUSY: begin
        w_step = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Share registers, kept in independent processes.
  // --------------------------------------------------------------------------
  always_comb begin
    sh1_d = sh1_q;
    if (w_load) begin
      sh1_d = w_load1;
    end else if (w_step) begin
      sh1_d = w_rot1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh1_q <= '0;
    end else begin
      sh1_q <= sh1_d;
    end
  end

  always_comb begin
    sh2_d = sh2_q;
    if (w_load) begin
      sh2_d = w_load2;
    end else if (w_step) begin
      sh2_d = w_rot2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh2_q <= '0;
    end else begin
      sh2_q <= sh2_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_sh1   = sh1_q;
  assign out_sh2   = sh2_q;

endmodule

`default_nettype wire

// File: tb/tb_prince_affine_inv_2sh_serial.sv
// ============================================================================
//  Module      : tb_prince_affine_inv_2sh_serial
//  Description : Directed bench for prince_affine_inv_2sh_serial. Five
//                instances (LANES = 1, 2, 4, 8, 16) share data inputs and
//                reset; each has its own handshake. Reference model:
//                A1(x) = L(x) ^ 4'h5, A2(x) = L(x),
//                L: y0=x0^x1, y1=x1^x2, y2=x2^x3, y3=x3.
//                Hand values: AINV1(0)=6, AINV1(F)=C, AINV2(F)=A,
//                AINV2(A)=C, AINV2(5)=6.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prince_affine_inv_2sh_serial;

  localparam int N_DUT = 5;
  localparam int MAIN  = 2;  // LANES = 4

  logic              clk;
  logic              rst_n;
  logic [63:0]       in_sh1;
  logic [63:0]       in_sh2;
  logic [N_DUT-1:0]  in_valid;
  logic [N_DUT-1:0]  in_ready;
  logic [N_DUT-1:0]  out_valid;
  logic [N_DUT-1:0]  out_ready;
  logic [63:0]       out_sh1 [N_DUT];
  logic [63:0]       out_sh2 [N_DUT];
`ifdef PRINCE_AFFINE_INV_REFRESH_EN
  logic [63:0]       in_rnd;
`endif

  int n_pass;
  int n_fail;
  int n_total;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  generate
    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
      prince_affine_inv_2sh_serial #(.LANES(1 << g), .NIBBLES(16)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid[g]),
        .in_ready  (in_ready[g]),
        .in_sh1    (in_sh1),
        .in_sh2    (in_sh2),
`ifdef PRINCE_AFFINE_INV_REFRESH_EN
        .in_rnd    (in_rnd),
`endif
        .out_valid (out_valid[g]),
        .out_ready (out_ready[g]),
        .out_sh1   (out_sh1[g]),
        .out_sh2   (out_sh2[g])
      );
    end
  endgenerate

  // ---------------- reference forward model ----------------
  function automatic logic [3:0] m_lin(input logic [3:0] x);
    return {x[3], x[2] ^ x[3], x[1] ^ x[2], x[0] ^ x[1]};
  endfunction

  function automatic logic [63:0] m_fwd64(input logic [63:0] v, input logic with_c);
    logic [63:0] r;
    for (int i = 0; i < 16; i++) begin
      r[4*i +: 4] = m_lin(v[4*i +: 4]) ^ (with_c ? 4'h5 : 4'h0);
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic transact(input int d, input logic [63:0] s1, input logic [63:0] s2,
                          output logic [63:0] o1, output logic [63:0] o2, output int lat);
    int guard;
    guard = 0;
    while (!in_ready[d] && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    in_sh1      = s1;
    in_sh2      = s2;
    in_valid[d] = 1'b1;
    @(posedge clk); #1;
    in_valid[d] = 1'b0;
    lat = 0;
    while (!out_valid[d] && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    o1 = out_sh1[d];
    o2 = out_sh2[d];
    out_ready[d] = 1'b1;
    @(posedge clk); #1;
    out_ready[d] = 1'b0;
  endtask

  localparam logic [63:0] REF1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] REF2 = 64'hFEDCBA9876543210;

  initial begin
    logic [63:0] fsh1, fsh2, o1, o2, v1, v2;
    int          lat;
    int          bad;

    n_pass = 0; n_fail = 0; n_total = 0;
    rst_n = 1'b0; in_valid = '0; out_ready = '0;
    in_sh1 = '0; in_sh2 = '0;
`ifdef PRINCE_AFFINE_INV_REFRESH_EN
    in_rnd = '0;
`endif
    fsh1 = m_fwd64(REF1, 1'b1);
    fsh2 = m_fwd64(REF2, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready",  64'(in_ready[MAIN]), 64'd1);
    check("reset_out_valid", 64'(out_valid[MAIN]), 64'd0);
    check("reset_out_sh1",   out_sh1[MAIN], 64'd0);
    check("reset_out_sh2",   out_sh2[MAIN], 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Hand-computed constant vectors.
    transact(MAIN, 64'h0, 64'h0, o1, o2, lat);
    check("zero_sh1", o1, 64'h6666666666666666);
    check("zero_sh2", o2, 64'h0);
    check("zero_lat", 64'(lat), 64'd4);
    transact(MAIN, {16{4'hF}}, {16{4'hF}}, o1, o2, lat);
    check("ones_sh1", o1, 64'hCCCCCCCCCCCCCCCC);
    check("ones_sh2", o2, 64'hAAAAAAAAAAAAAAAA);

    // Round trip through the forward model.
    transact(MAIN, fsh1, fsh2, o1, o2, lat);
    check("rt_sh1", o1, REF1);
    check("rt_sh2", o2, REF2);
    check("rt_lat", 64'(lat), 64'd4);

    // LANES sweep on the same vector.
    for (int d = 0; d < N_DUT; d++) begin
      transact(d, fsh1, fsh2, o1, o2, lat);
      check($sformatf("sweep%0d_sh1", d), o1, REF1);
      check($sformatf("sweep%0d_sh2", d), o2, REF2);
      check($sformatf("sweep%0d_lat", d), 64'(lat), 64'(16 >> d));
    end

    // Exhaustive nibble pairs on LANES=1: A(out1^out2) must equal s1^s2.
    for (int p = 0; p < 256; p++) begin
      logic [7:0] pp;
      pp = 8'(p);
      v1 = {16{pp[7:4]}};
      v2 = {16{pp[3:0]}};
      transact(0, v1, v2, o1, o2, lat);
      check($sformatf("exh_%02h", pp), m_fwd64(o1 ^ o2, 1'b1), v1 ^ v2);
      if (p == 255) check("exh_lat", 64'(lat), 64'd16);
    end

    // Backpressure: hold DONE, offer an input that must be ignored.
    in_sh1 = fsh1; in_sh2 = fsh2; in_valid[MAIN] = 1'b1;
    @(posedge clk); #1;
    in_valid[MAIN] = 1'b0;
    lat = 0;
    while (!out_valid[MAIN] && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_lat", 64'(lat), 64'd4);
    in_sh1 = 64'h0; in_sh2 = 64'h0; in_valid[MAIN] = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_sh1[MAIN] !== REF1 || out_sh2[MAIN] !== REF2 ||
          out_valid[MAIN] !== 1'b1 || in_ready[MAIN] !== 1'b0) bad++;
    end
    check("bp_hold_cycles", 64'(bad), 64'd0);
    check("bp_sh1", out_sh1[MAIN], REF1);
    check("bp_in_ready", 64'(in_ready[MAIN]), 64'd0);
    out_ready[MAIN] = 1'b1;
    @(posedge clk); #1;
    out_ready[MAIN] = 1'b0;
    check("bp_release_ready", 64'(in_ready[MAIN]), 64'd1);
    @(posedge clk); #1;
    in_valid[MAIN] = 1'b0;
    check("bp_next_accepted", 64'(in_ready[MAIN]), 64'd0);
    lat = 0;
    while (!out_valid[MAIN] && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    check("bp_next_sh1", out_sh1[MAIN], 64'h6666666666666666);
    check("bp_next_sh2", out_sh2[MAIN], 64'h0);
    out_ready[MAIN] = 1'b1;
    @(posedge clk); #1;
    out_ready[MAIN] = 1'b0;

    // Reset in the middle of BUSY (cnt = 2).
    in_sh1 = fsh1; in_sh2 = fsh2; in_valid[MAIN] = 1'b1;
    @(posedge clk); #1;
    in_valid[MAIN] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid[MAIN]), 64'd0);
    check("mid_rst_in_ready",  64'(in_ready[MAIN]), 64'd1);
    check("mid_rst_sh1",       out_sh1[MAIN], 64'd0);
    check("mid_rst_sh2",       out_sh2[MAIN], 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    transact(MAIN, fsh1, fsh2, o1, o2, lat);
    check("post_rst_sh1", o1, REF1);
    check("post_rst_sh2", o2, REF2);
    check("post_rst_lat", 64'(lat), 64'd4);

`ifdef PRINCE_AFFINE_INV_REFRESH_EN
    // Refresh adds AINV2(in_rnd) = C6C6... to both shares.
    in_rnd = 64'hA5A5A5A5A5A5A5A5;
    transact(MAIN, fsh1, fsh2, o1, o2, lat);
    in_rnd = 64'h0;
    check("rnd_xor", o1 ^ o2, REF1 ^ REF2);
    check("rnd_sh1_differs", 64'(o1 != REF1), 64'd1);
    check("rnd_sh1", o1, REF1 ^ 64'hC6C6C6C6C6C6C6C6);
    check("rnd_sh2", o2, REF2 ^ 64'hC6C6C6C6C6C6C6C6);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
